// File: rtl/mc_controller_pkg.sv
// Shared constants for the multicycle RV32 control unit:
// state codes, datapath select encodings, ALU ops and opcodes.
package mc_controller_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JALR     = 4'd11;
    localparam logic [3:0] S_LUI      = 4'd12;
    localparam logic [3:0] S_TRAP     = 4'd13;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    // ALU decode class handed from the FSM to mc_aludec
    localparam logic [1:0] AC_ADD = 2'd0;
    localparam logic [1:0] AC_SUB = 2'd1;
    localparam logic [1:0] AC_R   = 2'd2;
    localparam logic [1:0] AC_I   = 2'd3;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

endpackage

// File: rtl/mc_aludec.sv
// ALU control decode from FSM class, funct3 and funct7b5.
// Result is zero-extended to the configured control width.
module mc_aludec
    import mc_controller_pkg::*;
#(
    parameter int ALUC_W = 4
) (
    input  logic [1:0]        aluclass,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    output logic [ALUC_W-1:0] alu_control
);

    logic [3:0] code;

    always_comb begin
        code = ALU_ADD;
        unique case (aluclass)
            AC_ADD: code = ALU_ADD;
            AC_SUB: code = ALU_SUB;
            default: begin
                unique case (funct3)
                    // immediates have no subtract; bit 30 is imm data
                    3'b000: code = (aluclass == AC_R && funct7b5)
                                   ? ALU_SUB : ALU_ADD;
                    3'b001: code = ALU_SLL;
                    3'b010: code = ALU_SLT;
                    3'b011: code = ALU_SLTU;
                    3'b100: code = ALU_XOR;
                    3'b101: code = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110: code = ALU_OR;
                    3'b111: code = ALU_AND;
                    default: code = ALU_ADD;
                endcase
            end
        endcase
    end

    assign alu_control = ALUC_W'(code);

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32 control FSM: state register, next-state logic
// and per-state datapath control (Moore, gated by memory accept).
module mc_controller
    import mc_controller_pkg::*;
#(
    parameter int ALUC_W        = 4,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        op,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic              zero,
    input  logic              lt,
    input  logic              ltu,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              pc_write,
    output logic              adr_src,
    output logic              mem_write,
    output logic              ir_write,
    output logic [1:0]        result_src,
    output logic [1:0]        alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [2:0]        imm_src,
    output logic              reg_write,
    output logic [ALUC_W-1:0] alu_control,
    output logic              illegal
);

    logic [3:0] state;
    logic [3:0] next;
    logic [1:0] aluclass;
    logic       req_st;
    logic       accept;
    logic       cond;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= next;
        end
    end

    // reset kills any in-flight request immediately
    assign mem_req = req_st & rst_n;
    assign accept  = mem_req & (mem_ready | ~MEM_HANDSHAKE);

    always_comb begin
        cond = 1'b0;
        unique case (funct3)
            3'b000:  cond = zero;
            3'b001:  cond = ~zero;
            3'b100:  cond = lt;
            3'b101:  cond = ~lt;
            3'b110:  cond = ltu;
            3'b111:  cond = ~ltu;
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        next = S_FETCH;
        unique case (state)
            S_FETCH:    next = accept ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (op)
                    OP_LOAD,
                    OP_STORE:  next = S_MEMADR;
                    OP_R:      next = S_EXECR;
                    OP_I:      next = S_EXECI;
                    OP_BRANCH: next = S_BRANCH;
                    OP_JAL:    next = S_JAL;
                    OP_JALR:   next = S_JALR;
                    OP_LUI:    next = S_LUI;
                    default:   next = S_TRAP;
                endcase
            end
            S_MEMADR:   next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  next = accept ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: next = accept ? S_FETCH : S_MEMWRITE;
            S_EXECR,
            S_EXECI,
            S_JAL,
            S_LUI:      next = S_ALUWB;
            S_JALR:     next = S_JAL;
            S_BRANCH:   next = (funct3[2:1] == 2'b01) ? S_TRAP : S_FETCH;
            default:    next = S_FETCH;
        endcase
    end

    always_comb begin
        req_st     = 1'b0;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        imm_src    = IMM_I;
        reg_write  = 1'b0;
        aluclass   = AC_ADD;
        illegal    = 1'b0;
        unique case (state)
            S_FETCH: begin
                req_st     = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
                ir_write   = accept;
                pc_write   = accept;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_B;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                req_st  = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                req_st    = 1'b1;
                adr_src   = 1'b1;
                mem_write = accept;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                aluclass  = AC_R;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                aluclass  = AC_I;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = SRCA_RS1;
                aluclass  = AC_SUB;
                pc_write  = cond;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
            end
            S_JALR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_LUI: begin
                alu_src_a = SRCA_ZERO;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_U;
            end
            S_TRAP:  illegal = 1'b1;
            default: req_st = 1'b0;
        endcase
    end

    mc_aludec #(.ALUC_W(ALUC_W)) u_aludec (
        .aluclass    (aluclass),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Bench: per-instruction expected control traces built from the
// instruction rules, compared cycle by cycle against the controller.
module tb_mc_controller;

    typedef struct packed {
        logic       mem_req;
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] imm_src;
        logic       reg_write;
        logic [3:0] alu_control;
        logic       illegal;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       lt = 1'b0;
    logic       ltu = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, pc_write, adr_src, mem_write, ir_write;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] imm_src;
    logic       reg_write, illegal;
    logic [3:0] alu_control;

    int total = 0;
    int bad = 0;
    ctl_t eq[$];
    logic mq[$];

    always #5 clk = ~clk;

    mc_controller #(.ALUC_W(4), .MEM_HANDSHAKE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .lt(lt), .ltu(ltu),
        .mem_ready(mem_ready), .mem_req(mem_req),
        .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write),
        .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_src(imm_src),
        .reg_write(reg_write), .alu_control(alu_control),
        .illegal(illegal)
    );

    function automatic ctl_t obs();
        ctl_t c;
        c.mem_req = mem_req;
        c.pc_write = pc_write;
        c.adr_src = adr_src;
        c.mem_write = mem_write;
        c.ir_write = ir_write;
        c.result_src = result_src;
        c.alu_src_a = alu_src_a;
        c.alu_src_b = alu_src_b;
        c.imm_src = imm_src;
        c.reg_write = reg_write;
        c.alu_control = alu_control;
        c.illegal = illegal;
        return c;
    endfunction

    task automatic check(input string tag, input ctl_t got, input ctl_t want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s t=%0t got=%b want=%b", tag, $time, got, want);
        end
    endtask

    // ALU op named by the instruction's mnemonic
    function automatic logic [3:0] alu_of(input bit rtype, input logic [2:0] f3,
                                          input logic b5);
        int m[8];
        int code;
        m = '{0, 7, 5, 6, 4, 8, 3, 2};
        code = m[f3];
        if (f3 == 3'd0 && rtype && b5) code = 1;
        if (f3 == 3'd5 && b5) code = 9;
        return 4'(code);
    endfunction

    function automatic ctl_t fetch_c(input bit acc);
        ctl_t c = '0;
        c.mem_req = 1'b1;
        c.alu_src_b = 2'b10;
        c.result_src = 2'b10;
        c.ir_write = acc;
        c.pc_write = acc;
        return c;
    endfunction

    task automatic push(input ctl_t c, input logic mr);
        eq.push_back(c);
        mq.push_back(mr);
    endtask

    task automatic run_instr(input string tag, input logic [6:0] o,
                             input logic [2:0] f3, input logic b5,
                             input logic z, input logic l, input logic lu,
                             input int fw, input int mw, input int cut);
        ctl_t c;
        bit taken;
        eq.delete();
        mq.delete();
        repeat (fw) push(fetch_c(0), 1'b0);
        push(fetch_c(1), 1'b1);
        c = '0; c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; c.imm_src = 3'b010;
        push(c, 1'($urandom_range(1)));
        case (o)
            7'b0000011, 7'b0100011: begin
                c = '0; c.alu_src_a = 2'b10; c.alu_src_b = 2'b01;
                c.imm_src = (o == 7'b0100011) ? 3'b001 : 3'b000;
                push(c, 1'($urandom_range(1)));
                c = '0; c.mem_req = 1'b1; c.adr_src = 1'b1;
                repeat (mw) push(c, 1'b0);
                c.mem_write = (o == 7'b0100011);
                push(c, 1'b1);
                if (o == 7'b0000011) begin
                    c = '0; c.result_src = 2'b01; c.reg_write = 1'b1;
                    push(c, 1'($urandom_range(1)));
                end
            end
            7'b0110011, 7'b0010011: begin
                c = '0; c.alu_src_a = 2'b10;
                c.alu_src_b = (o == 7'b0010011) ? 2'b01 : 2'b00;
                c.alu_control = alu_of(o == 7'b0110011, f3, b5);
                push(c, 1'($urandom_range(1)));
                c = '0; c.reg_write = 1'b1;
                push(c, 1'($urandom_range(1)));
            end
            7'b1100011: begin
                case (f3)
                    3'd0: taken = z;
                    3'd1: taken = !z;
                    3'd4: taken = l;
                    3'd5: taken = !l;
                    3'd6: taken = lu;
                    3'd7: taken = !lu;
                    default: taken = 0;
                endcase
                c = '0; c.alu_src_a = 2'b10; c.alu_control = 4'd1;
                c.pc_write = taken;
                push(c, 1'($urandom_range(1)));
                if (f3 == 3'd2 || f3 == 3'd3) begin
                    c = '0; c.illegal = 1'b1;
                    push(c, 1'($urandom_range(1)));
                end
            end
            7'b1101111, 7'b1100111, 7'b0110111: begin
                c = '0;
                if (o == 7'b1100111) begin
                    c.alu_src_a = 2'b10; c.alu_src_b = 2'b01;
                    push(c, 1'($urandom_range(1)));
                    c = '0;
                end
                if (o == 7'b0110111) begin
                    c.alu_src_a = 2'b11; c.alu_src_b = 2'b01; c.imm_src = 3'b100;
                end else begin
                    c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_write = 1'b1;
                end
                push(c, 1'($urandom_range(1)));
                c = '0; c.reg_write = 1'b1;
                push(c, 1'($urandom_range(1)));
            end
            default: begin
                c = '0; c.illegal = 1'b1;
                push(c, 1'($urandom_range(1)));
            end
        endcase
        op = o; funct3 = f3; funct7b5 = b5; zero = z; lt = l; ltu = lu;
        for (int i = 0; i < eq.size(); i++) begin
            if (cut >= 0 && i >= cut) break;
            mem_ready = mq[i];
            @(negedge clk);
            check(tag, obs(), eq[i]);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        ctl_t rv;
        logic [6:0] ops[10];
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0001111, 7'b1110011};
        rv = '0; rv.alu_src_b = 2'b10; rv.result_src = 2'b10;

        #1;
        check("reset_async", obs(), rv);
        @(posedge clk); #1;
        check("reset_held", obs(), rv);
        rst_n = 1'b1;

        run_instr("lw_wait2", 7'b0000011, 3'd2, 1'b0, 0, 0, 0, 0, 2, -1);
        run_instr("sw", 7'b0100011, 3'd2, 1'b0, 0, 0, 0, 1, 1, -1);
        run_instr("bne_taken", 7'b1100011, 3'd1, 1'b0, 0, 0, 0, 0, 0, -1);
        run_instr("bne_not", 7'b1100011, 3'd1, 1'b0, 1, 0, 0, 0, 0, -1);
        run_instr("sub", 7'b0110011, 3'd0, 1'b1, 0, 0, 0, 0, 0, -1);
        run_instr("addi_b30", 7'b0010011, 3'd0, 1'b1, 0, 0, 0, 0, 0, -1);
        run_instr("srai", 7'b0010011, 3'd5, 1'b1, 0, 0, 0, 0, 0, -1);
        run_instr("fence_trap", 7'b0001111, 3'd0, 1'b0, 0, 0, 0, 0, 0, -1);
        run_instr("br_f3_2", 7'b1100011, 3'd2, 1'b0, 1, 1, 1, 0, 0, -1);
        run_instr("jalr", 7'b1100111, 3'd0, 1'b0, 0, 0, 0, 0, 0, -1);

        // abort a store while it waits for memory
        run_instr("sw_abort", 7'b0100011, 3'd2, 1'b0, 0, 0, 0, 0, 3, 4);
        rst_n = 1'b0;
        #1;
        check("abort_async", obs(), rv);
        @(negedge clk);
        check("abort_held", obs(), rv);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_instr("after_abort", 7'b0110111, 3'd0, 1'b0, 0, 0, 0, 0, 0, -1);

        for (int n = 0; n < 80; n++) begin
            logic [6:0] o;
            o = ops[$urandom_range(9)];
            if ($urandom_range(9) == 0) o = 7'($urandom);
            run_instr("rand", o, 3'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom), $urandom_range(2),
                      $urandom_range(3), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
